irq_vector_ctrl: RTL and testbench
==================================

Name: irq_vector_ctrl

Overview:
Parametrised interrupt recognition and vector generation unit for the 65xx core family, generalising the core's single IRQ/NMI/reset logic to NUM_IRQ maskable channels. Each channel is level or edge triggered and has its own vector. NMI is edge detected and reset has top priority. The core supplies the recognition strobe (T0, or the branch T2 sample) and the acknowledge strobe (the I-flag set cycle); the block returns the intg request plus a stable vector address for the vector fetch cycles.

Parameters:
NUM_IRQ, 8, number of maskable IRQ channels (1..16)
VEC_HI, 8'hFF, high byte of every vector address
RES_VEC_LO, 8'hFC, reset vector low byte
NMI_VEC_LO, 8'hFA, NMI vector low byte
BRK_VEC_LO, 8'hFE, BRK vector low byte
IRQ_VEC_BASE, 8'hE0, channel n vector low byte = IRQ_VEC_BASE + 2*n (mod 256)
NMI_BUG_FIX, 0, 1 = a software BRK never consumes or redirects to a pending NMI

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ready  in  1  core advance enable; sample_stb and ack_stb are ignored while low
irq_in  in  NUM_IRQ  raw channel requests, active high
irq_edge  in  NUM_IRQ  per channel: 1 = rising-edge mode, 0 = level mode
irq_en  in  NUM_IRQ  per-channel enable mask
irq_clr  in  NUM_IRQ  clears the sticky edge-pending bit, one pulse per bit
nmi_in  in  1  NMI request; rising edge is detected
p_i  in  1  core I flag
brk_sw  in  1  current BRK is software (core B flag = 1)
sample_stb  in  1  recognition point (T0 or branch T2)
ack_stb  in  1  interrupt accepted (I-flag load cycle)
intg  out  1  interrupt/reset sequence requested; core forces IR = 00
resp  out  1  reset sequence in progress
vector_lo  out  8  vector low byte (core ORs in bit0 for the high fetch)
vector_hi  out  8  constant VEC_HI
active_src  out  5  latched source: 0..NUM_IRQ-1 = channel, 16 = NMI, 17 = reset, 31 = none
pending  out  NUM_IRQ  registered pending bits, after the enable mask

Behaviour:
- Reset values: intg=1, resp=1, active_src=17, nmi_pend=0, nmi_last=0, all edge-pending bits=0, irq_q=0, pending=0.
- resp clears on the first sample_stb with ready=1 and reset=0. It drives no other state.
- Input registration: irq_q <= irq_in every cycle, independent of ready. This adds 1 cycle of latency; there is no synchroniser.
- Edge mode:
  - A rising edge (irq_in & ~irq_q) sets the sticky bit.
  - irq_clr, or an ack of that channel, clears it.
  - A set in the same cycle as a clear wins.
- Level mode: the pending bit is irq_q, with no storage.
- pending = raw pending & irq_en, registered.
- NMI:
  - nmi_in & ~nmi_last sets nmi_pend. nmi_last <= nmi_in every cycle.
  - An edge arriving in the same cycle as sample_stb is seen at the next recognition point.
- Recognition, on sample_stb & ready:
  - Condition: reset | nmi_pend | (|pending & ~p_i).
  - If true, set intg=1 and latch active_src using priority reset > NMI > lowest-numbered pending channel.
  - If false, intg and active_src are unchanged.
- Acknowledge, on ack_stb & ready with no recognition in the same cycle (recognition has priority):
  - intg <= 0.
  - If nmi_pend and not (NMI_BUG_FIX & brk_sw): clear nmi_pend.
  - If active_src is an edge-mode channel: clear that channel's sticky bit.
  - active_src <= 31.
- vector_lo, combinational, first match wins:
  1. resp → RES_VEC_LO
  2. nmi_pend & ~(NMI_BUG_FIX & brk_sw) → NMI_VEC_LO. An NMI arriving before ack hijacks the vector.
  3. active_src < NUM_IRQ → IRQ_VEC_BASE + 2*active_src
  4. otherwise → BRK_VEC_LO
- A channel whose pending bit drops after being latched, such as a level source deasserting, still vectors to its own vector. The ack then clears nothing.
- p_i only masks recognition. It never clears pending bits.
- Asserting reset mid-sequence returns every register to its reset value in the next cycle.

Test Plan:
- Reset → intg=1, resp=1, vector_lo=FC, active_src=17. Pulse sample_stb with reset low → resp=0. Pulse ack → intg=0, vector_lo=FE, active_src=31.
- Ch3 level, ch5 edge, both enabled, p_i=0, both raised, then sample → active_src=3, vector_lo=E6. Ack, drop ch3, sample → active_src=5, vector_lo=EA. Ack → ch5 pending cleared.
- p_i=1 with ch2 pending, then sample → intg stays 0. Set p_i=0 and sample again → intg=1, vector_lo=E4.
- Ch1 recognised; nmi_in rises 2 cycles before ack → vector_lo switches to FA. Ack → nmi_pend=0. Also: nmi_in held high for 10 cycles → exactly one recognition.
- NMI_BUG_FIX=1, brk_sw=1, NMI pending → vector_lo=FE and ack leaves nmi_pend=1. With NMI_BUG_FIX=0 → vector_lo=FA and nmi_pend is cleared.
- ready=0 for 3 cycles during sample_stb/ack_stb → no state change, while ch0 edge capture still occurs. Edge and irq_clr on ch0 in the same cycle → pending[0]=1.

Source files
------------

// File: rtl/irq_vector_ctrl.sv
// Interrupt recognition and vector generation for a 65xx-style core.
// Supports NUM_IRQ maskable level/edge channels, an edge-detected NMI and reset.
module irq_vector_ctrl #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [7:0]  VEC_HI       = 8'hFF,
  parameter logic [7:0]  RES_VEC_LO   = 8'hFC,
  parameter logic [7:0]  NMI_VEC_LO   = 8'hFA,
  parameter logic [7:0]  BRK_VEC_LO   = 8'hFE,
  parameter logic [7:0]  IRQ_VEC_BASE = 8'hE0,
  parameter bit          NMI_BUG_FIX  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_edge,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic [NUM_IRQ-1:0] irq_clr,
  input  logic               nmi_in,
  input  logic               p_i,
  input  logic               brk_sw,
  input  logic               sample_stb,
  input  logic               ack_stb,
  output logic               intg,
  output logic               resp,
  output logic [7:0]         vector_lo,
  output logic [7:0]         vector_hi,
  output logic [4:0]         active_src,
  output logic [NUM_IRQ-1:0] pending
);

  localparam logic [4:0] SRC_NMI  = 5'd16;
  localparam logic [4:0] SRC_RES  = 5'd17;
  localparam logic [4:0] SRC_NONE = 5'd31;

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               nmi_last_q, nmi_last_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic               intg_q, intg_d;
  logic               resp_q, resp_d;
  logic [4:0]         active_src_q, active_src_d;

  logic [NUM_IRQ-1:0] raw_pend;
  logic [4:0]         first_src;
  logic               nmi_keep;
  logic               rec_fire;
  logic               ack_fire;
  logic               ack_clr;

  always_comb begin
    irq_d      = irq_in;
    nmi_last_d = nmi_in;
    raw_pend   = (irq_edge & edge_pend_q) | (~irq_edge & irq_q);
    pending_d  = raw_pend & irq_en;

    // Lowest-numbered pending channel wins; scan high to low so low overwrites.
    first_src = SRC_NONE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) first_src = 5'(i);
    end

    // With the fix enabled a software BRK neither consumes nor vectors to NMI.
    nmi_keep = NMI_BUG_FIX && brk_sw;
    rec_fire = ready && sample_stb && (reset || nmi_pend_q || ((|pending_q) && !p_i));
    ack_fire = ready && ack_stb && !rec_fire;

    intg_d       = intg_q;
    active_src_d = active_src_q;
    if (rec_fire) begin
      intg_d = 1'b1;
      if (reset)           active_src_d = SRC_RES;
      else if (nmi_pend_q) active_src_d = SRC_NMI;
      else                 active_src_d = first_src;
    end else if (ack_fire) begin
      intg_d       = 1'b0;
      active_src_d = SRC_NONE;
    end

    resp_d = resp_q && !(ready && sample_stb);

    // A new edge in the same cycle as a clear keeps the bit set.
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr        = ack_fire && (active_src_q == 5'(i)) && irq_edge[i];
      edge_pend_d[i] = (irq_in[i] && !irq_q[i]) ||
                       (edge_pend_q[i] && !(irq_clr[i] || ack_clr));
    end

    nmi_pend_d = (nmi_in && !nmi_last_q) || (nmi_pend_q && !(ack_fire && !nmi_keep));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q        <= '0;
      edge_pend_q  <= '0;
      pending_q    <= '0;
      nmi_last_q   <= 1'b0;
      nmi_pend_q   <= 1'b0;
      intg_q       <= 1'b1;
      resp_q       <= 1'b1;
      active_src_q <= SRC_RES;
    end else begin
      irq_q        <= irq_d;
      edge_pend_q  <= edge_pend_d;
      pending_q    <= pending_d;
      nmi_last_q   <= nmi_last_d;
      nmi_pend_q   <= nmi_pend_d;
      intg_q       <= intg_d;
      resp_q       <= resp_d;
      active_src_q <= active_src_d;
    end
  end

  // A pending NMI redirects the vector up to the acknowledge cycle.
  always_comb begin
    if (resp_q)                          vector_lo = RES_VEC_LO;
    else if (nmi_pend_q && !nmi_keep)    vector_lo = NMI_VEC_LO;
    else if (active_src_q < 5'(NUM_IRQ)) vector_lo = IRQ_VEC_BASE + {2'b00, active_src_q, 1'b0};
    else                                 vector_lo = BRK_VEC_LO;
  end

  assign vector_hi  = VEC_HI;
  assign intg       = intg_q;
  assign resp       = resp_q;
  assign active_src = active_src_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Bench for irq_vector_ctrl: instance a has NMI_BUG_FIX=0, instance b has NMI_BUG_FIX=1.
// Expected {intg, resp, active_src, vector_lo} words go through a scoreboard queue.
module tb_irq_vector_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset, ready, nmi_in, p_i, brk_sw, sample_stb, ack_stb;
  logic [N-1:0] irq_in, irq_edge, irq_en, irq_clr;

  logic         intg_a, resp_a, intg_b, resp_b;
  logic [7:0]   vlo_a, vhi_a, vlo_b, vhi_b;
  logic [4:0]   src_a, src_b;
  logic [N-1:0] pend_a, pend_b;

  logic [14:0]  exp_q[$];
  logic [14:0]  exp_v, obs_v;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  irq_vector_ctrl #(.NUM_IRQ(N), .NMI_BUG_FIX(1'b0)) dut_a (
    .clk(clk), .reset(reset), .ready(ready), .irq_in(irq_in), .irq_edge(irq_edge),
    .irq_en(irq_en), .irq_clr(irq_clr), .nmi_in(nmi_in), .p_i(p_i), .brk_sw(brk_sw),
    .sample_stb(sample_stb), .ack_stb(ack_stb), .intg(intg_a), .resp(resp_a),
    .vector_lo(vlo_a), .vector_hi(vhi_a), .active_src(src_a), .pending(pend_a));

  irq_vector_ctrl #(.NUM_IRQ(N), .NMI_BUG_FIX(1'b1)) dut_b (
    .clk(clk), .reset(reset), .ready(ready), .irq_in(irq_in), .irq_edge(irq_edge),
    .irq_en(irq_en), .irq_clr(irq_clr), .nmi_in(nmi_in), .p_i(p_i), .brk_sw(brk_sw),
    .sample_stb(sample_stb), .ack_stb(ack_stb), .intg(intg_b), .resp(resp_b),
    .vector_lo(vlo_b), .vector_hi(vhi_b), .active_src(src_b), .pending(pend_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sample;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
  endtask

  task automatic pulse_ack;
    ack_stb = 1'b1;
    tick();
    ack_stb = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    exp_q.push_back({1'b1, 1'b1, 5'd17, 8'hFC});
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset_state: got %h want %h", obs_v, exp_v); end
    vectors++;
    if (pend_a !== 8'h00 || vhi_a !== 8'hFF) begin
      miscompares++; $display("FAIL reset_pend_hi: got %h/%h want 00/ff", pend_a, vhi_a);
    end
    reset = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 5'd17, 8'hFE});
    pulse_sample();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL resp_clear: got %h want %h", obs_v, exp_v); end
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
    pulse_ack();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset_ack: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_priority;
    irq_edge = 8'h20;
    irq_en   = 8'hFF;
    irq_in   = 8'h28;
    tick();
    tick();
    vectors++;
    if (pend_a !== 8'h28) begin miscompares++; $display("FAIL prio_pend: got %h want 28", pend_a); end
    exp_q.push_back({1'b1, 1'b0, 5'd3, 8'hE6});
    pulse_sample();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL prio_ch3: got %h want %h", obs_v, exp_v); end
    pulse_ack();
    irq_in = 8'h20;
    tick();
    tick();
    exp_q.push_back({1'b1, 1'b0, 5'd5, 8'hEA});
    pulse_sample();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL prio_ch5: got %h want %h", obs_v, exp_v); end
    pulse_ack();
    tick();
    vectors++;
    if (pend_a !== 8'h00) begin miscompares++; $display("FAIL ack_clears_edge: got %h want 00", pend_a); end
    irq_in = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_mask;
    irq_edge = 8'h00;
    irq_in   = 8'h04;
    p_i      = 1'b1;
    tick();
    tick();
    vectors++;
    if (pend_a !== 8'h04) begin miscompares++; $display("FAIL mask_pend: got %h want 04", pend_a); end
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
    pulse_sample();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL mask_blocks: got %h want %h", obs_v, exp_v); end
    p_i = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 5'd2, 8'hE4});
    pulse_sample();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL mask_open: got %h want %h", obs_v, exp_v); end
    pulse_ack();
  endtask

  task automatic test_nmi;
    int   rec_count;
    logic prev;
    irq_in = 8'h02;
    tick();
    tick();
    pulse_sample();
    nmi_in = 1'b1;
    tick();
    exp_q.push_back({1'b1, 1'b0, 5'd1, 8'hFA});
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL nmi_hijack: got %h want %h", obs_v, exp_v); end
    tick();
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
    pulse_ack();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL nmi_ack_clear: got %h want %h", obs_v, exp_v); end
    irq_in = 8'h00;
    nmi_in = 1'b0;
    tick();
    tick();
    rec_count = 0;
    nmi_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prev       = intg_a;
      sample_stb = ~intg_a;
      ack_stb    = intg_a;
      tick();
      if (intg_a && !prev) rec_count++;
    end
    sample_stb = 1'b0;
    ack_stb    = 1'b0;
    vectors++;
    if (rec_count !== 1 || intg_a !== 1'b0) begin
      miscompares++; $display("FAIL nmi_held_once: got %0d recognitions intg=%b want 1 intg=0", rec_count, intg_a);
    end
    nmi_in = 1'b0;
    tick();
  endtask

  task automatic test_nmi_bug_fix;
    brk_sw = 1'b1;
    nmi_in = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFA});
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
    tick();
    for (int k = 0; k < 2; k++) begin
      exp_v = exp_q.pop_front();
      obs_v = (k == 0) ? {intg_a, resp_a, src_a, vlo_a} : {intg_b, resp_b, src_b, vlo_b};
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL fix_vec_%0d: got %h want %h", k, obs_v, exp_v); end
    end
    pulse_ack();
    brk_sw = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFA});
    tick();
    for (int k = 0; k < 2; k++) begin
      exp_v = exp_q.pop_front();
      obs_v = (k == 0) ? {intg_a, resp_a, src_a, vlo_a} : {intg_b, resp_b, src_b, vlo_b};
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL fix_keep_%0d: got %h want %h", k, obs_v, exp_v); end
    end
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
    exp_q.push_back({1'b1, 1'b0, 5'd16, 8'hFA});
    pulse_sample();
    for (int k = 0; k < 2; k++) begin
      exp_v = exp_q.pop_front();
      obs_v = (k == 0) ? {intg_a, resp_a, src_a, vlo_a} : {intg_b, resp_b, src_b, vlo_b};
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL fix_rec_%0d: got %h want %h", k, obs_v, exp_v); end
    end
    exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
    pulse_ack();
    exp_v = exp_q.pop_front();
    obs_v = {intg_b, resp_b, src_b, vlo_b};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL fix_final_ack: got %h want %h", obs_v, exp_v); end
    nmi_in = 1'b0;
    tick();
  endtask

  task automatic test_ready_stall;
    irq_edge = 8'h01;
    irq_in   = 8'h10;
    tick();
    tick();
    ready      = 1'b0;
    sample_stb = 1'b1;
    ack_stb    = 1'b1;
    irq_in     = 8'h11;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 1'b0, 5'd31, 8'hFE});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {intg_a, resp_a, src_a, vlo_a};
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL stall_%0d: got %h want %h", i, obs_v, exp_v); end
    end
    ack_stb = 1'b0;
    sample_stb = 1'b0;
    vectors++;
    if (pend_a !== 8'h11) begin miscompares++; $display("FAIL stall_edge_capture: got %h want 11", pend_a); end
    ready = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 5'd0, 8'hE0});
    pulse_sample();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL stall_release: got %h want %h", obs_v, exp_v); end
    pulse_ack();
    irq_in = 8'h10;
    tick();
    irq_in  = 8'h11;
    irq_clr = 8'h01;
    tick();
    irq_clr = 8'h00;
    tick();
    vectors++;
    if (pend_a !== 8'h11) begin miscompares++; $display("FAIL set_beats_clr: got %h want 11", pend_a); end
    irq_clr = 8'h01;
    tick();
    irq_clr = 8'h00;
    tick();
    vectors++;
    if (pend_a !== 8'h10) begin miscompares++; $display("FAIL irq_clr: got %h want 10", pend_a); end
  endtask

  task automatic test_reset_mid;
    exp_q.push_back({1'b1, 1'b0, 5'd4, 8'hE8});
    pulse_sample();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v) begin miscompares++; $display("FAIL mid_rec_ch4: got %h want %h", obs_v, exp_v); end
    reset = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 5'd17, 8'hFC});
    tick();
    exp_v = exp_q.pop_front();
    obs_v = {intg_a, resp_a, src_a, vlo_a};
    vectors++;
    if (obs_v !== exp_v || pend_a !== 8'h00) begin
      miscompares++; $display("FAIL mid_reset: got %h pend %h want %h pend 00", obs_v, pend_a, exp_v);
    end
    reset  = 1'b0;
    irq_in = 8'h00;
    tick();
  endtask

  initial begin
    reset = 1'b1; ready = 1'b1; nmi_in = 1'b0; p_i = 1'b0; brk_sw = 1'b0;
    sample_stb = 1'b0; ack_stb = 1'b0;
    irq_in = '0; irq_edge = '0; irq_en = '0; irq_clr = '0;
    test_reset();
    test_priority();
    test_mask();
    test_nmi();
    test_nmi_bug_fix();
    test_ready_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
